// File: rtl/mc_pkg.sv
// Shared types for the multicycle ARM-subset control unit:
// FSM state enum, mux-select/ALU encodings, condition codes and check.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_BLINK,
    S_UNKNOWN
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] SRCB_ZERO = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef enum logic [3:0] {
    C_EQ, C_NE, C_CS, C_CC,
    C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT,
    C_GT, C_LE, C_AL, C_NV
  } cond_e;

  // f = {N,Z,C,V}
  function automatic logic cond_check(
    input logic [3:0] cond,
    input logic [3:0] f
  );
    logic n, z, c, v;
    logic r;
    {n, z, c, v} = f;
    r = 1'b0;
    unique case (cond_e'(cond))
      C_EQ: r = z;
      C_NE: r = ~z;
      C_CS: r = c;
      C_CC: r = ~c;
      C_MI: r = n;
      C_PL: r = ~n;
      C_VS: r = v;
      C_VC: r = ~v;
      C_HI: r = c & ~z;
      C_LS: r = ~c | z;
      C_GE: r = (n == v);
      C_LT: r = (n != v);
      C_GT: r = ~z & (n == v);
      C_LE: r = z | (n != v);
      C_AL: r = 1'b1;
      C_NV: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between controller (master) and datapath (slave):
// instruction fields/ALU flags in, mux selects and write enables out.
interface multicycle_ctrl_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [2:0] ALUControl;
  logic       LinkSel;

  modport master (
    input  Op, Funct, Rd, Cond, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite,
    output AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    output ImmSrc, RegSrc, ALUControl, LinkSel
  );

  modport slave (
    output Op, Funct, Rd, Cond, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite,
    input  AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    input  ImmSrc, RegSrc, ALUControl, LinkSel
  );
endinterface

// File: rtl/cond_unit.sv
// Conditional execution: NZCV flag register, condex_q latched in
// DECODE, and gating of PC/Reg/Mem write enables (all 0 in reset).
module cond_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       cond_latch,
  input  logic       fetch,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       pcs,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write
);

  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;

  // condex_q holds from DECODE to the next DECODE, so flags
  // written during EXECUTE cannot affect this instruction.
  always_comb begin
    flags_d  = flags_q;
    condex_d = condex_q;
    if (cond_latch)
      condex_d = cond_check(cond, flags_q);
    if (flag_w[1] & condex_q)
      flags_d[3:2] = alu_flags[3:2];
    if (flag_w[0] & condex_q)
      flags_d[1:0] = alu_flags[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= '0;
      condex_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  assign reg_write = ~reset & reg_w & condex_q;
  assign mem_write = ~reset & mem_w & condex_q;
  assign pc_write  = ~reset & (fetch | (pcs & condex_q));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: main FSM, ALU decoder, cond_unit.
// Ports: clk, reset (sync, active-high), bus (master). Option MC_BL_LINK_EN.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  state_e     state_q, state_d;
  logic       fetch, decode;
  logic       ir_write, adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src;
  logic       reg_w, mem_w, branch, alu_op, link_sel;
  logic [2:0] alu_ctl;
  logic       alu_known, alu_addsub;
  logic [1:0] flag_w;
  logic       pcs;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    fetch      = 1'b0;
    decode     = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RD2;
    result_src = RES_ALUOUT;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    link_sel   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        fetch      = 1'b1;
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        decode     = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        unique case (bus.Op)
          2'b00: state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01: state_d = S_MEMADR;
`ifdef MC_BL_LINK_EN
          2'b10: state_d = bus.Funct[4] ? S_BLINK : S_BRANCH;
`else
          2'b10: state_d = S_BRANCH;
`endif
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = SRCB_IMM;
        state_d   = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECUTER: begin
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_b = SRCB_IMM;
        alu_op    = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_w      = 1'b1;
      end
`ifdef MC_BL_LINK_EN
      S_BLINK: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_ZERO;
        result_src = RES_ALURES;
        reg_w      = 1'b1;
        link_sel   = 1'b1;
        state_d    = S_BRANCH;
      end
`endif
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURES;
        branch     = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Unsupported DP functs still add, but never write flags.
  always_comb begin
    alu_ctl    = ALU_ADD;
    alu_known  = 1'b0;
    alu_addsub = 1'b0;
    if (alu_op) begin
      unique case (bus.Funct[4:1])
        4'b0100: begin
          alu_ctl    = ALU_ADD;
          alu_known  = 1'b1;
          alu_addsub = 1'b1;
        end
        4'b0010: begin
          alu_ctl    = ALU_SUB;
          alu_known  = 1'b1;
          alu_addsub = 1'b1;
        end
        4'b0000: begin
          alu_ctl   = ALU_AND;
          alu_known = 1'b1;
        end
        4'b1100: begin
          alu_ctl   = ALU_ORR;
          alu_known = 1'b1;
        end
        default: alu_ctl = ALU_ADD;
      endcase
    end
  end

  assign flag_w = {bus.Funct[0] & alu_known,
                   bus.Funct[0] & alu_addsub};

  // The BL link write targets R14, never the PC.
  assign pcs = branch |
               (reg_w & (bus.Rd == 4'hF) & ~link_sel);

  cond_unit u_cond (
    .clk        (clk),
    .reset      (reset),
    .cond       (bus.Cond),
    .alu_flags  (bus.ALUFlags),
    .flag_w     (flag_w),
    .cond_latch (decode),
    .fetch      (fetch),
    .reg_w      (reg_w),
    .mem_w      (mem_w),
    .pcs        (pcs),
    .pc_write   (bus.PCWrite),
    .reg_write  (bus.RegWrite),
    .mem_write  (bus.MemWrite)
  );

  assign bus.IRWrite    = ir_write & ~reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = alu_ctl;
  assign bus.LinkSel    = link_sel;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: instruction table + scoreboard of
// per-cycle control words, plus hand-written reset corner cases.
module tb_multicycle_ctrl;

  logic clk;
  logic reset;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int T_F   = 0;
  localparam int T_D   = 1;
  localparam int T_MA  = 2;
  localparam int T_MR  = 3;
  localparam int T_MWB = 4;
  localparam int T_MW  = 5;
  localparam int T_ER  = 6;
  localparam int T_EI  = 7;
  localparam int T_AWB = 8;
  localparam int T_BR  = 9;
  localparam int T_BL  = 10;
  localparam int T_UN  = 11;

  typedef enum int {K_DPR, K_DPI, K_LDR, K_STR, K_B, K_BL, K_UNK} kind_e;

  typedef struct {
    kind_e      kind;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cond;
    logic [3:0] af;
    logic       taken;
    logic [2:0] alu;
  } vec_t;

  typedef struct {
    logic [13:0] val;
    logic [13:0] mask;
    int          id;
    int          cyc;
  } sb_t;

  sb_t sb[$];
  int  n_pass;
  int  n_total;

  localparam int NV = 22;
  vec_t vecs[NV];

  function automatic int seq_len(kind_e k);
    case (k)
      K_LDR:   return 5;
      K_STR:   return 4;
      K_DPR:   return 4;
      K_DPI:   return 4;
`ifdef MC_BL_LINK_EN
      K_BL:    return 4;
`else
      K_BL:    return 3;
`endif
      default: return 3;
    endcase
  endfunction

  function automatic int seq_st(kind_e k, int i);
    if (i == 0) return T_F;
    if (i == 1) return T_D;
    case (k)
      K_LDR:   return (i == 2) ? T_MA : (i == 3) ? T_MR : T_MWB;
      K_STR:   return (i == 2) ? T_MA : T_MW;
      K_DPR:   return (i == 2) ? T_ER : T_AWB;
      K_DPI:   return (i == 2) ? T_EI : T_AWB;
      K_B:     return T_BR;
`ifdef MC_BL_LINK_EN
      K_BL:    return (i == 2) ? T_BL : T_BR;
`else
      K_BL:    return T_BR;
`endif
      default: return T_UN;
    endcase
  endfunction

  // word: {PCW,MemW,RegW,IRW,AdrSrc,SrcA,SrcB[2],Res[2],Link,ALUCtl[3]}
  function automatic logic [27:0] exp_word(int st, vec_t v);
    logic [13:0] m, w;
    logic        rd15;
    rd15 = (v.rd == 4'hF);
    m = 14'b11110000001111;
    w = '0;
    if (st == T_ER || st == T_EI) w[2:0] = v.alu;
    case (st)
      T_F: begin
        m[9:4] = '1; w[13] = 1'b1; w[10] = 1'b1;
        w[8] = 1'b1; w[7:6] = 2'b10; w[5:4] = 2'b10;
      end
      T_D: begin
        m[8:4] = '1; w[8] = 1'b1;
        w[7:6] = 2'b10; w[5:4] = 2'b10;
      end
      T_MA: begin
        m[8:6] = '1; w[7:6] = 2'b01;
      end
      T_MR: begin
        m[9] = 1'b1; w[9] = 1'b1;
      end
      T_MWB: begin
        m[5:4] = '1; w[5:4] = 2'b01;
        w[11] = v.taken; w[13] = v.taken & rd15;
      end
      T_MW: begin
        m[9] = 1'b1; w[9] = 1'b1; w[12] = v.taken;
      end
      T_ER: m[8:6] = '1;
      T_EI: begin
        m[8:6] = '1; w[7:6] = 2'b01;
      end
      T_AWB: begin
        m[5:4] = '1;
        w[11] = v.taken; w[13] = v.taken & rd15;
      end
      T_BL: begin
        m[8:4] = '1; w[8] = 1'b1; w[7:6] = 2'b11;
        w[5:4] = 2'b10; w[11] = v.taken; w[3] = 1'b1;
      end
      T_BR: begin
        m[8:4] = '1; w[7:6] = 2'b01; w[5:4] = 2'b10;
        w[13] = v.taken;
      end
      default: ;
    endcase
    return {m, w};
  endfunction

  function automatic logic [13:0] act_word();
    return {bus.PCWrite, bus.MemWrite, bus.RegWrite,
            bus.IRWrite, bus.AdrSrc, bus.ALUSrcA,
            bus.ALUSrcB, bus.ResultSrc, bus.LinkSel,
            bus.ALUControl};
  endfunction

  task automatic chk(input string nm, input logic [13:0] act,
                     input logic [13:0] exp, input logic [13:0] msk);
    n_total++;
    if ((act & msk) !== (exp & msk))
      $display("FAIL %s: got %b want %b (mask %b)",
               nm, act, exp, msk);
    else
      n_pass++;
  endtask

  task automatic drive(input vec_t v);
    bus.Op       = v.op;
    bus.Funct    = v.funct;
    bus.Rd       = v.rd;
    bus.Cond     = v.cond;
    bus.ALUFlags = v.af;
  endtask

  task automatic run(input vec_t v, input int id, input int stop);
    int          n;
    logic [27:0] e;
    sb_t         s;
    n = seq_len(v.kind);
    if (stop < n) n = stop;
    for (int i = 0; i < n; i++) begin
      e = exp_word(seq_st(v.kind, i), v);
      sb.push_back('{e[13:0], e[27:14], id, i});
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) drive(v);
      #1;
      s = sb.pop_front();
      chk($sformatf("v%0d.c%0d", s.id, s.cyc),
          act_word(), s.val, s.mask);
    end
  endtask

  task automatic reset_now(input string nm);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk(nm, act_word(), 14'h0, 14'b11110000000000);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t        v;
  logic [27:0] e0;

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;

    vecs[0]  = '{K_DPI, 2'b00, 6'b101000, 4'd1,  4'hE, 4'h0, 1'b1, 3'b000};
    vecs[1]  = '{K_DPR, 2'b00, 6'b000101, 4'd2,  4'hE, 4'h4, 1'b1, 3'b001};
    vecs[2]  = '{K_B,   2'b10, 6'b100000, 4'd0,  4'h0, 4'h0, 1'b1, 3'b000};
    vecs[3]  = '{K_B,   2'b10, 6'b100000, 4'd0,  4'h1, 4'h0, 1'b0, 3'b000};
    vecs[4]  = '{K_LDR, 2'b01, 6'b011001, 4'd2,  4'hE, 4'h0, 1'b1, 3'b000};
    vecs[5]  = '{K_STR, 2'b01, 6'b011000, 4'd3,  4'hE, 4'h0, 1'b1, 3'b000};
    vecs[6]  = '{K_DPR, 2'b00, 6'b001000, 4'd15, 4'hE, 4'h0, 1'b1, 3'b000};
    vecs[7]  = '{K_DPI, 2'b00, 6'b111001, 4'd4,  4'hE, 4'hB, 1'b1, 3'b011};
    vecs[8]  = '{K_DPR, 2'b00, 6'b000000, 4'd5,  4'h4, 4'h0, 1'b1, 3'b010};
    vecs[9]  = '{K_DPR, 2'b00, 6'b000000, 4'd15, 4'h5, 4'h0, 1'b0, 3'b010};
    vecs[10] = '{K_DPR, 2'b00, 6'b001001, 4'd6,  4'hE, 4'h3, 1'b1, 3'b000};
    vecs[11] = '{K_STR, 2'b01, 6'b011000, 4'd7,  4'h8, 4'h0, 1'b1, 3'b000};
    vecs[12] = '{K_LDR, 2'b01, 6'b011001, 4'd8,  4'hA, 4'h0, 1'b0, 3'b000};
    vecs[13] = '{K_UNK, 2'b11, 6'b000000, 4'd9,  4'hE, 4'h0, 1'b1, 3'b000};
    vecs[14] = '{K_DPR, 2'b00, 6'b000101, 4'd1,  4'h0, 4'h4, 1'b0, 3'b001};
    vecs[15] = '{K_B,   2'b10, 6'b100000, 4'd0,  4'h0, 4'h0, 1'b0, 3'b000};
    vecs[16] = '{K_DPR, 2'b00, 6'b000011, 4'd1,  4'hE, 4'h4, 1'b1, 3'b000};
    vecs[17] = '{K_B,   2'b10, 6'b100000, 4'd0,  4'h0, 4'h0, 1'b0, 3'b000};
    vecs[18] = '{K_DPR, 2'b00, 6'b000101, 4'd3,  4'h1, 4'h4, 1'b1, 3'b001};
    vecs[19] = '{K_B,   2'b10, 6'b100000, 4'd0,  4'h0, 4'h0, 1'b1, 3'b000};
    vecs[20] = '{K_DPI, 2'b00, 6'b101000, 4'd1,  4'hF, 4'h0, 1'b0, 3'b000};
    vecs[21] = '{K_BL,  2'b10, 6'b110000, 4'd0,  4'hE, 4'h0, 1'b1, 3'b000};

    drive(vecs[0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst_c%0d", i), act_word(),
          14'h0, 14'b11110000000000);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < NV; i++)
      run(vecs[i], i, 99);

    // ADD to R15, reset lands in ALUWB
    v = '{K_DPI, 2'b00, 6'b101000, 4'd15, 4'hE, 4'h0, 1'b1, 3'b000};
    run(v, 100, 3);
    reset_now("rst_aluwb");

    // flags cleared by reset: BEQ must not branch
    v = '{K_B, 2'b10, 6'b100000, 4'd0, 4'h0, 4'h0, 1'b0, 3'b000};
    run(v, 101, 99);

`ifdef MC_BL_LINK_EN
    v = '{K_BL, 2'b10, 6'b110000, 4'd0, 4'hE, 4'h0, 1'b1, 3'b000};
    run(v, 102, 2);
    reset_now("rst_blink");
`endif

    v = '{K_DPI, 2'b00, 6'b101000, 4'd15, 4'hE, 4'h0, 1'b1, 3'b000};
    run(v, 103, 99);

    e0 = exp_word(T_F, v);
    @(negedge clk);
    #1;
    chk("final_fetch", act_word(), e0[13:0], e0[27:14]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
